// File: rtl/reg_target_demux.sv
// reg_target_demux
//   Decodes one host register port onto NTGT targets, each owning a
//   base/mask address window. Each target may add wait states through its
//   ready line. Unmapped addresses and targets that never answer get an
//   error response. The first faulting address is captured, and a sticky
//   error interrupt is raised.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no transaction; accepts reg_en_i
//   WAIT  | request issued to tgt_en_o[sel]; waiting for ready or timeout
//   ERR   | unmapped address; error response goes out this cycle
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   reg_*_i          host request (reg_en_i is a single-cycle pulse)
//   reg_rdata_o      read data, valid while reg_ready_o=1
//   reg_ready_o      single-cycle completion pulse
//   reg_err_o        error qualifier, only together with reg_ready_o
//   tgt_en_o         one-hot single-cycle request to the selected target
//   tgt_addr_o       latched request address, broadcast to all targets
//   tgt_wdata_o      latched write data, broadcast to all targets
//   tgt_we_o         latched write enable, broadcast to all targets
//   tgt_be_o         latched byte enables, broadcast to all targets
//   tgt_rdata_i      packed read data of all targets; target i in [32*i+:32]
//   tgt_ready_i      per-target completion; only the selected one counts
//   err_irq_o        sticky error interrupt
//   err_addr_o       address of the first captured error
//   err_clr_i        clears err_irq_o
module reg_target_demux #(
  parameter int unsigned        NTGT      = 4,
  parameter logic [NTGT*32-1:0] TGT_BASE  = {NTGT{32'h0}},
  parameter logic [NTGT*32-1:0] TGT_MASK  = {NTGT{32'hFFFF_F000}},
  parameter int unsigned        TIMEOUT   = 255,
  parameter logic [31:0]        ERR_RDATA = 32'hBADC_0FFE
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 reg_en_i,
  input  logic [31:0]          reg_addr_i,
  input  logic [31:0]          reg_wdata_i,
  input  logic                 reg_we_i,
  input  logic [3:0]           reg_be_i,
  output logic [31:0]          reg_rdata_o,
  output logic                 reg_ready_o,
  output logic                 reg_err_o,
  output logic [NTGT-1:0]      tgt_en_o,
  output logic [31:0]          tgt_addr_o,
  output logic [31:0]          tgt_wdata_o,
  output logic                 tgt_we_o,
  output logic [3:0]           tgt_be_o,
  input  logic [NTGT*32-1:0]   tgt_rdata_i,
  input  logic [NTGT-1:0]      tgt_ready_i,
  output logic                 err_irq_o,
  output logic [31:0]          err_addr_o,
  input  logic                 err_clr_i
);

  localparam int unsigned SW        = (NTGT > 1) ? $clog2(NTGT) : 1;
  // A zero TIMEOUT still needs a one-bit counter so the widths stay legal.
  localparam int unsigned CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sel_q;
  logic [CW-1:0]   cnt_q;

  logic            hit_any;
  logic [SW-1:0]   hit_idx;
  logic            sel_ready;
  logic [31:0]     sel_rdata;
  logic            to_hit;
  logic            err_done;

  // Scan from the top index down so that the lowest hitting index is the
  // last one assigned; overlapping windows resolve to the lowest target.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = int'(NTGT) - 1; i >= 0; i--) begin
      if ((reg_addr_i & TGT_MASK[32*i +: 32]) ==
          (TGT_BASE[32*i +: 32] & TGT_MASK[32*i +: 32])) begin
        hit_any = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  always_comb begin
    sel_ready = tgt_ready_i[sel_q];
    sel_rdata = tgt_rdata_i[32*sel_q +: 32];
    to_hit    = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  end

  always_comb begin
    state_d     = state_q;
    reg_ready_o = 1'b0;
    reg_err_o   = 1'b0;
    reg_rdata_o = '0;
    case (state_q)
      S_IDLE: begin
        if (reg_en_i) begin
          state_d = hit_any ? S_WAIT : S_ERR;
        end
      end
      S_WAIT: begin
        if (sel_ready) begin
          reg_ready_o = 1'b1;
          reg_rdata_o = sel_rdata;
          state_d     = S_IDLE;
        end else if (to_hit) begin
          reg_ready_o = 1'b1;
          reg_err_o   = 1'b1;
          reg_rdata_o = ERR_RDATA;
          state_d     = S_IDLE;
        end
      end
      S_ERR: begin
        reg_ready_o = 1'b1;
        reg_err_o   = 1'b1;
        reg_rdata_o = ERR_RDATA;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign err_done = reg_ready_o & reg_err_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      tgt_en_o    <= '0;
      tgt_addr_o  <= '0;
      tgt_wdata_o <= '0;
      tgt_we_o    <= 1'b0;
      tgt_be_o    <= '0;
      err_irq_o   <= 1'b0;
      err_addr_o  <= '0;
    end else begin
      state_q  <= state_d;
      tgt_en_o <= '0;

      if (state_q == S_IDLE && reg_en_i) begin
        tgt_addr_o  <= reg_addr_i;
        tgt_wdata_o <= reg_wdata_i;
        tgt_we_o    <= reg_we_i;
        tgt_be_o    <= reg_be_i;
        sel_q       <= hit_idx;
        if (hit_any) begin
          tgt_en_o <= NTGT'(1) << hit_idx;
        end
      end

      if (state_q != S_WAIT) begin
        cnt_q <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end

      // A clear arriving with an error completion is treated as applied
      // first, so the new error re-arms the capture.
      if (err_done && (!err_irq_o || err_clr_i)) begin
        err_irq_o  <= 1'b1;
        err_addr_o <= tgt_addr_o;
      end else if (err_clr_i) begin
        err_irq_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_target_demux.sv
module tb_reg_target_demux;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         reg_en_i = 1'b0;
  logic [31:0]  reg_addr_i = '0;
  logic [31:0]  reg_wdata_i = '0;
  logic         reg_we_i = 1'b0;
  logic [3:0]   reg_be_i = '0;
  logic         err_clr_i = 1'b0;
  logic [31:0]  reg_rdata_o;
  logic         reg_ready_o, reg_err_o;
  logic [3:0]   tgt_en_o;
  logic [31:0]  tgt_addr_o, tgt_wdata_o;
  logic         tgt_we_o;
  logic [3:0]   tgt_be_o;
  logic         err_irq_o;
  logic [31:0]  err_addr_o;
  logic [127:0] tgt_rdata_i;
  logic [3:0]   tgt_ready_i;

  logic [31:0]  o_rdata;
  logic         o_ready, o_err;
  logic [3:0]   o_en;
  logic [31:0]  o_addr, o_wdata;
  logic         o_we;
  logic [3:0]   o_be;
  logic         o_irq;
  logic [31:0]  o_eaddr;

  logic [2:0]   d2 = '0;
  logic         rdy3 = 1'b0;
  int           cyc = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  // target 2 answers three cycles after its request pulse
  always @(posedge clk_i) d2 <= {d2[1:0], tgt_en_o[2]};

  assign tgt_rdata_i = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
  assign tgt_ready_i = {rdy3, d2[2], 2'b11};

  reg_target_demux #(
    .NTGT(4),
    .TGT_BASE({32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
    .TIMEOUT(8)
  ) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .reg_en_i(reg_en_i), .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i), .reg_we_i(reg_we_i), .reg_be_i(reg_be_i),
    .reg_rdata_o(reg_rdata_o), .reg_ready_o(reg_ready_o), .reg_err_o(reg_err_o),
    .tgt_en_o(tgt_en_o), .tgt_addr_o(tgt_addr_o), .tgt_wdata_o(tgt_wdata_o),
    .tgt_we_o(tgt_we_o), .tgt_be_o(tgt_be_o), .tgt_rdata_i(tgt_rdata_i),
    .tgt_ready_i(tgt_ready_i), .err_irq_o(err_irq_o), .err_addr_o(err_addr_o),
    .err_clr_i(err_clr_i)
  );

  // overlapping-window instance: target 0 covers 0x0000_0000..0x0000_FFFF
  reg_target_demux #(
    .NTGT(4),
    .TGT_BASE({32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
    .TGT_MASK({32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000})
  ) u_ovl (
    .clk_i(clk_i), .rst_i(rst_i), .reg_en_i(reg_en_i), .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i), .reg_we_i(reg_we_i), .reg_be_i(reg_be_i),
    .reg_rdata_o(o_rdata), .reg_ready_o(o_ready), .reg_err_o(o_err),
    .tgt_en_o(o_en), .tgt_addr_o(o_addr), .tgt_wdata_o(o_wdata),
    .tgt_we_o(o_we), .tgt_be_o(o_be), .tgt_rdata_i(tgt_rdata_i),
    .tgt_ready_i(4'hF), .err_irq_o(o_irq), .err_addr_o(o_eaddr),
    .err_clr_i(err_clr_i)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [3:0]  en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    int          cyc;
  } req_t;

  rsp_t rsp_q[$];
  req_t req_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_resp = 0;
  int   n_exp = 0;

  // scoreboard monitor
  always @(negedge clk_i) begin
    if (reg_ready_o === 1'b1) begin
      n_resp++;
      checks++;
      if (rsp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected act_ready=1 exp_ready=0 cyc=%0d", cyc);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        if (reg_err_o !== e.err || cyc != e.cyc ||
            (e.chk_rd && reg_rdata_o !== e.rdata)) begin
          failures++;
          $display("FAIL rsp act err=%b rdata=%h cyc=%0d exp err=%b rdata=%h cyc=%0d",
                   reg_err_o, reg_rdata_o, cyc, e.err, e.rdata, e.cyc);
        end
      end
    end
    if (tgt_en_o !== 4'b0000 && !$isunknown(tgt_en_o)) begin
      checks++;
      if (req_q.size() == 0) begin
        failures++;
        $display("FAIL req_unexpected act_en=%b exp_en=0000 cyc=%0d", tgt_en_o, cyc);
      end else begin
        req_t r;
        r = req_q.pop_front();
        if (tgt_en_o !== r.en || tgt_addr_o !== r.addr || tgt_we_o !== r.we ||
            (r.we && tgt_wdata_o !== r.wdata) || cyc != r.cyc) begin
          failures++;
          $display("FAIL req act en=%b addr=%h we=%b wdata=%h cyc=%0d exp en=%b addr=%h we=%b wdata=%h cyc=%0d",
                   tgt_en_o, tgt_addr_o, tgt_we_o, tgt_wdata_o, cyc,
                   r.en, r.addr, r.we, r.wdata, r.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge of the following cycle
  task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd,
                       input logic [3:0] be, input logic [3:0] en_exp,
                       input logic err_exp, input logic [31:0] rd_exp,
                       input int lat, input logic chk_rd, input bit want_rsp);
    if (en_exp != 4'b0000) req_q.push_back('{en_exp, a, wd, we, cyc + 1});
    if (want_rsp) begin
      rsp_q.push_back('{rd_exp, err_exp, chk_rd, cyc + lat});
      n_exp++;
    end
    reg_en_i    = 1'b1;
    reg_addr_i  = a;
    reg_we_i    = we;
    reg_wdata_i = wd;
    reg_be_i    = be;
    @(negedge clk_i);
    reg_en_i    = 1'b0;
  endtask

  task automatic wait_rsp(input string nm);
    for (int i = 0; i < 40; i++) begin
      if (n_resp >= n_exp) break;
      @(posedge clk_i);
    end
    @(negedge clk_i);
    checks++;
    if (n_resp < n_exp) begin
      failures++;
      $display("FAIL %s_timeout act_resp=%0d exp_resp=%0d", nm, n_resp, n_exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ready"}, {31'd0, reg_ready_o}, 32'd0);
    chk({nm, "_err"},   {31'd0, reg_err_o},   32'd0);
    chk({nm, "_rdata"}, reg_rdata_o,          32'd0);
    chk({nm, "_en"},    {28'd0, tgt_en_o},    32'd0);
    chk({nm, "_addr"},  tgt_addr_o,           32'd0);
    chk({nm, "_wdata"}, tgt_wdata_o,          32'd0);
    chk({nm, "_we_be"}, {27'd0, tgt_we_o, tgt_be_o}, 32'd0);
    chk({nm, "_irq"},   {31'd0, err_irq_o},   32'd0);
    chk({nm, "_eaddr"}, err_addr_o,           32'd0);
  endtask

  task automatic clr_pulse();
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_zero("reset");

    // plain reads, ready tied high
    issue(32'h0000_1004, 1'b0, '0, 4'hF, 4'b0010, 1'b0, 32'hB1B1_0001, 1, 1'b1, 1'b1);
    wait_rsp("rd_1004");
    issue(32'h0000_0008, 1'b0, '0, 4'hF, 4'b0001, 1'b0, 32'hA0A0_0000, 1, 1'b1, 1'b1);
    wait_rsp("rd_0008");

    // write to target 2 with three wait cycles
    issue(32'h0000_2010, 1'b1, 32'hA5A5_5A5A, 4'hF, 4'b0100, 1'b0, '0, 4, 1'b0, 1'b1);
    chk("wr_be", {28'd0, tgt_be_o}, 32'h0000_000F);
    wait_rsp("wr_2010");

    // unmapped read
    issue(32'h0000_8000, 1'b0, '0, 4'hF, 4'b0000, 1'b1, 32'hBADC_0FFE, 1, 1'b1, 1'b1);
    wait_rsp("rd_8000");
    chk("irq_after_unmapped", {31'd0, err_irq_o}, 32'd1);
    chk("eaddr_after_unmapped", err_addr_o, 32'h0000_8000);
    clr_pulse();
    chk("irq_after_clr1", {31'd0, err_irq_o}, 32'd0);
    chk("eaddr_hold_clr1", err_addr_o, 32'h0000_8000);

    // target 3 never answers: timeout after 8 cycles
    rdy3 = 1'b0;
    issue(32'h0000_3000, 1'b0, '0, 4'hF, 4'b1000, 1'b1, 32'hBADC_0FFE, 8, 1'b1, 1'b1);
    wait_rsp("rd_3000_to");
    chk("irq_after_timeout", {31'd0, err_irq_o}, 32'd1);
    chk("eaddr_after_timeout", err_addr_o, 32'h0000_3000);
    issue(32'h0000_9000, 1'b0, '0, 4'hF, 4'b0000, 1'b1, 32'hBADC_0FFE, 1, 1'b1, 1'b1);
    wait_rsp("rd_9000");
    chk("eaddr_not_overwritten", err_addr_o, 32'h0000_3000);
    clr_pulse();
    chk("irq_after_clr2", {31'd0, err_irq_o}, 32'd0);

    rdy3 = 1'b1;
    issue(32'h0000_3004, 1'b0, '0, 4'hF, 4'b1000, 1'b0, 32'hD3D3_0003, 1, 1'b1, 1'b1);
    wait_rsp("rd_3004");

    // overlap: the second instance must pick target 0
    issue(32'h0000_1000, 1'b0, '0, 4'hF, 4'b0010, 1'b0, 32'hB1B1_0001, 1, 1'b1, 1'b1);
    chk("ovl_en", {28'd0, o_en}, 32'h0000_0001);
    chk("ovl_rdata", o_rdata, 32'hA0A0_0000);
    wait_rsp("rd_1000");

    // clear coinciding with an error completion: the error wins
    issue(32'h0000_B000, 1'b0, '0, 4'hF, 4'b0000, 1'b1, 32'hBADC_0FFE, 1, 1'b1, 1'b1);
    wait_rsp("rd_b000");
    chk("eaddr_b000", err_addr_o, 32'h0000_B000);
    issue(32'h0000_C000, 1'b0, '0, 4'hF, 4'b0000, 1'b1, 32'hBADC_0FFE, 1, 1'b1, 1'b1);
    clr_pulse();
    wait_rsp("rd_c000");
    chk("irq_clr_vs_err", {31'd0, err_irq_o}, 32'd1);
    chk("eaddr_clr_vs_err", err_addr_o, 32'h0000_C000);

    // reset while waiting on target 2; its late ready must be ignored
    issue(32'h0000_2000, 1'b1, 32'h1234_5678, 4'h3, 4'b0100, 1'b0, '0, 0, 1'b0, 1'b0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk_zero("rst_in_wait");
    repeat (5) @(negedge clk_i);
    chk("no_late_rsp", n_resp, n_exp);
    issue(32'h0000_1008, 1'b0, '0, 4'hF, 4'b0010, 1'b0, 32'hB1B1_0001, 1, 1'b1, 1'b1);
    wait_rsp("rd_after_rst");

    repeat (2) @(negedge clk_i);
    chk("rsp_queue_empty", rsp_q.size(), 32'd0);
    chk("req_queue_empty", req_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout act_time=%0t exp=finished", $time);
    $fatal(1, "bench did not finish");
  end

endmodule
